// File: rtl/lfsr_pair_sequencer.sv
// Pairs consecutive decoded LFSR words whose timestamps are close enough, hands each
// pair to an external polynomial finder and reports its result or a timeout.
`timescale 1ns/1ps
module lfsr_pair_sequencer #(
  parameter logic [23:0] MAX_GAP        = 24'h1FFFFF,
  parameter logic [19:0] FINDER_TIMEOUT = 20'd200000
) (
  input  logic        clk_72MHz,
  input  logic        reset,
  input  logic        word_valid,
  input  logic [16:0] word_data,
  input  logic [23:0] word_ts,
  output logic [16:0] decoded_data,
  output logic [16:0] decoded_data1,
  output logic [23:0] ts_last_data,
  output logic [23:0] ts_last_data1,
  output logic        finder_enable,
  input  logic        finder_ready,
  input  logic [16:0] finder_polynomial,
  input  logic [16:0] finder_iteration,
  output logic [16:0] result_polynomial,
  output logic [16:0] result_iteration,
  output logic [23:0] result_ts,
  output logic        result_valid,
  output logic        result_fail,
  output logic        busy,
  output logic [7:0]  drop_count
);
  typedef enum logic [2:0] {EMPTY, HAVE_FIRST, START, WAIT_DONE, RELEASE} state_t;

  state_t      state, state_nx;
  logic [19:0] wait_cnt;
  logic [23:0] gap;
  logic        pair_ok, timed_out;

  // Wrap-around subtraction so a timestamp rollover still yields the true distance.
  assign gap       = word_ts - ts_last_data;
  assign pair_ok   = (gap != '0) && (gap <= MAX_GAP) && (word_data != decoded_data);
  assign timed_out = (wait_cnt + 20'd1) >= FINDER_TIMEOUT;

  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:      if (word_valid) state_nx = HAVE_FIRST;
      HAVE_FIRST: if (word_valid && pair_ok) state_nx = START;
      // A ready that never falls still ends the job through the same timeout.
      START:      if (!finder_ready) state_nx = WAIT_DONE;
                  else if (timed_out) state_nx = RELEASE;
      WAIT_DONE:  if (finder_ready || timed_out) state_nx = RELEASE;
      RELEASE:    state_nx = HAVE_FIRST;
      default:    state_nx = EMPTY;
    endcase
  end

  always_comb begin
    finder_enable = (state == START) || (state == WAIT_DONE);
    busy          = (state == START) || (state == WAIT_DONE) || (state == RELEASE);
  end

  always_ff @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      decoded_data      <= '0;
      decoded_data1     <= '0;
      ts_last_data      <= '0;
      ts_last_data1     <= '0;
      result_polynomial <= '0;
      result_iteration  <= '0;
      result_ts         <= '0;
      result_valid      <= 1'b0;
      result_fail       <= 1'b0;
      drop_count        <= '0;
      wait_cnt          <= '0;
    end else begin
      result_valid <= 1'b0;
      result_fail  <= 1'b0;
      if (word_valid && busy && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      case (state)
        EMPTY: if (word_valid) begin
          decoded_data <= word_data;
          ts_last_data <= word_ts;
        end
        HAVE_FIRST: if (word_valid) begin
          if (pair_ok) begin
            decoded_data1 <= word_data;
            ts_last_data1 <= word_ts;
            wait_cnt      <= '0;
          end else begin
            decoded_data <= word_data;
            ts_last_data <= word_ts;
          end
        end
        START: begin
          if (!finder_ready)  wait_cnt    <= '0;
          else if (timed_out) result_fail <= 1'b1;
          else                wait_cnt    <= wait_cnt + 20'd1;
        end
        WAIT_DONE: begin
          if (finder_ready) begin
            result_polynomial <= finder_polynomial;
            result_iteration  <= finder_iteration;
            result_ts         <= ts_last_data1;
            // A zero polynomial means the finder gave up.
            if (finder_polynomial == '0) result_fail  <= 1'b1;
            else                         result_valid <= 1'b1;
          end else if (timed_out) begin
            result_fail <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 20'd1;
          end
        end
        RELEASE: begin
          decoded_data <= decoded_data1;
          ts_last_data <= ts_last_data1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_pair_sequencer.sv
// Bench for lfsr_pair_sequencer: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a job-level model of the sequencer.
`timescale 1ns/1ps
module tb_lfsr_pair_sequencer;
  localparam logic [23:0] MAX_GAP = 24'h1FFFFF;
  localparam int          TMO     = 400;

  logic        clk_72MHz = 1'b0;
  logic        reset = 1'b0;
  logic        word_valid = 1'b0;
  logic [16:0] word_data = '0;
  logic [23:0] word_ts = '0;
  logic [16:0] decoded_data, decoded_data1, result_polynomial, result_iteration;
  logic [23:0] ts_last_data, ts_last_data1, result_ts;
  logic        finder_enable, result_valid, result_fail, busy;
  logic [7:0]  drop_count;
  logic        finder_ready = 1'b1;
  logic [16:0] finder_polynomial = '0, finder_iteration = '0;

  int tests = 0, fails = 0;
  bit chk_en = 0;

  lfsr_pair_sequencer #(.MAX_GAP(MAX_GAP), .FINDER_TIMEOUT(20'(TMO))) dut (
    .clk_72MHz(clk_72MHz), .reset(reset), .word_valid(word_valid), .word_data(word_data),
    .word_ts(word_ts), .decoded_data(decoded_data), .decoded_data1(decoded_data1),
    .ts_last_data(ts_last_data), .ts_last_data1(ts_last_data1), .finder_enable(finder_enable),
    .finder_ready(finder_ready), .finder_polynomial(finder_polynomial),
    .finder_iteration(finder_iteration), .result_polynomial(result_polynomial),
    .result_iteration(result_iteration), .result_ts(result_ts), .result_valid(result_valid),
    .result_fail(result_fail), .busy(busy), .drop_count(drop_count));

  always #5 clk_72MHz = ~clk_72MHz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Finder stand-in: 0 = drop ready then raise after fdelay cycles, 1 = never re-raise,
  // 2 = never drop ready.
  int fmode = 0, fdelay = 20, fcnt = 0;
  bit frun = 0;
  logic [16:0] fpoly = '0, fiter = '0;
  always @(negedge clk_72MHz) begin
    if (!finder_enable) begin
      frun = 0; fcnt = 0; finder_ready = 1'b1;
    end else if (!frun) begin
      frun = 1; fcnt = 0;
      if (fmode != 2) finder_ready = 1'b0;
    end else begin
      fcnt++;
      if (fmode == 0 && fcnt == fdelay) begin
        finder_ready = 1'b1; finder_polynomial = fpoly; finder_iteration = fiter;
      end
    end
  end

  // Job-level model: phase 0 nothing held, 1 one word held, 2 request raised waiting for
  // the finder to go busy, 3 finder working, 4 one-cycle handoff.
  int          m_phase = 0, m_waited = 0, m_drops = 0;
  logic [16:0] m_d0 = '0, m_d1 = '0, m_rp = '0, m_ri = '0;
  logic [23:0] m_t0 = '0, m_t1 = '0, m_rts = '0, m_gap;
  logic        m_rv = 0, m_rf = 0;
  always @(posedge clk_72MHz or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_waited = 0; m_drops = 0;
      m_d0 = '0; m_d1 = '0; m_rp = '0; m_ri = '0; m_t0 = '0; m_t1 = '0; m_rts = '0;
      m_rv = 0; m_rf = 0;
    end else begin
      m_rv = 0; m_rf = 0;
      if (word_valid && m_phase >= 2) m_drops++;
      case (m_phase)
        0: if (word_valid) begin m_d0 = word_data; m_t0 = word_ts; m_phase = 1; end
        1: if (word_valid) begin
          m_gap = word_ts - m_t0;
          if (m_gap == 0 || m_gap > MAX_GAP || word_data == m_d0) begin
            m_d0 = word_data; m_t0 = word_ts;
          end else begin
            m_d1 = word_data; m_t1 = word_ts; m_phase = 2; m_waited = 0;
          end
        end
        2: if (!finder_ready) begin m_phase = 3; m_waited = 0; end
           else begin m_waited++; if (m_waited == TMO) begin m_rf = 1; m_phase = 4; end end
        3: begin
          m_waited++;
          if (finder_ready) begin
            m_rp = finder_polynomial; m_ri = finder_iteration; m_rts = m_t1;
            if (finder_polynomial == 0) m_rf = 1; else m_rv = 1;
            m_phase = 4;
          end else if (m_waited == TMO) begin
            m_rf = 1; m_phase = 4;
          end
        end
        default: begin m_d0 = m_d1; m_t0 = m_t1; m_phase = 1; end
      endcase
    end
  end

  always @(negedge clk_72MHz) if (chk_en) begin
    chk("decoded_data", 32'(decoded_data), 32'(m_d0));
    chk("decoded_data1", 32'(decoded_data1), 32'(m_d1));
    chk("ts_last_data", 32'(ts_last_data), 32'(m_t0));
    chk("ts_last_data1", 32'(ts_last_data1), 32'(m_t1));
    chk("finder_enable", 32'(finder_enable), 32'(m_phase == 2 || m_phase == 3));
    chk("busy", 32'(busy), 32'(m_phase >= 2));
    chk("result_valid", 32'(result_valid), 32'(m_rv));
    chk("result_fail", 32'(result_fail), 32'(m_rf));
    chk("result_polynomial", 32'(result_polynomial), 32'(m_rp));
    chk("result_iteration", 32'(result_iteration), 32'(m_ri));
    chk("result_ts", 32'(result_ts), 32'(m_rts));
    chk("drop_count", 32'(drop_count), (m_drops > 255) ? 32'd255 : 32'(m_drops));
  end

  task automatic tick();
    @(posedge clk_72MHz); #1;
  endtask

  task automatic send(input logic [16:0] d, input logic [23:0] t);
    word_valid = 1'b1; word_data = d; word_ts = t;
    tick();
    word_valid = 1'b0;
  endtask

  // Returns at the negedge where a result pulse is visible, counting negedges waited.
  task automatic wait_pulse(input int limit, output int n);
    n = 0;
    do begin @(negedge clk_72MHz); n++; end while (!(result_valid || result_fail) && n < limit);
    if (!(result_valid || result_fail)) begin
      tests++; fails++;
      $display("FAIL wait_pulse: no result pulse after %0d cycles, expected one", n);
    end
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [16:0] last_d = '0;
  logic [23:0] cur_ts = '0;
  int n;

  initial begin
    #2 reset = 1'b1; chk_en = 1;
    repeat (2) @(posedge clk_72MHz);
    @(negedge clk_72MHz);
    chk("rst_decoded_data", 32'(decoded_data), 32'h0);
    chk("rst_ts_last_data1", 32'(ts_last_data1), 32'h0);
    chk("rst_finder_enable", 32'(finder_enable), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);
    tick(); reset = 1'b0;

    // Basic pair, finder answers after 20 cycles.
    fmode = 0; fdelay = 20; fpoly = 17'h1D258; fiter = 17'h00080;
    send(17'h1A2B3, 24'h000100);
    @(negedge clk_72MHz); chk("first_word", 32'(decoded_data), 32'h1A2B3);
    tick(); send(17'h0F00F, 24'h000900);
    @(negedge clk_72MHz);
    chk("pair_enable", 32'(finder_enable), 32'h1);
    chk("pair_newer", 32'(decoded_data1), 32'h0F00F);
    wait_pulse(100, n);
    chk("res_valid", 32'(result_valid), 32'h1);
    chk("res_fail", 32'(result_fail), 32'h0);
    chk("res_poly", 32'(result_polynomial), 32'h1D258);
    chk("res_iter", 32'(result_iteration), 32'h00080);
    chk("res_ts", 32'(result_ts), 32'h000900);
    chk("release_enable", 32'(finder_enable), 32'h0);
    tick(); @(negedge clk_72MHz);
    chk("promote_older", 32'(decoded_data), 32'h0F00F);
    chk("promote_idle", 32'(busy), 32'h0);
    tick();

    // Timestamp wrap.
    fpoly = 17'h0ABCD; fiter = 17'h00123;
    send(17'h11111, 24'hFFFF00); tick();
    send(17'h05555, 24'h000100);
    @(negedge clk_72MHz);
    chk("wrap_enable", 32'(finder_enable), 32'h1);
    chk("wrap_ts1", 32'(ts_last_data1), 32'h000100);
    wait_pulse(100, n);
    chk("wrap_valid", 32'(result_valid), 32'h1);
    chk("wrap_poly", 32'(result_polynomial), 32'h0ABCD);
    tick(); tick();

    // Gap too large: older word replaced.
    send(17'h06666, 24'h200100);
    @(negedge clk_72MHz);
    chk("biggap_enable", 32'(finder_enable), 32'h0);
    chk("biggap_replace", 32'(decoded_data), 32'h06666);
    tick();

    // Finder never re-raises ready.
    fmode = 1;
    send(17'h07777, 24'h200180);
    wait_pulse(TMO + 50, n);
    chk("tmo_cycles", 32'(n), 32'(TMO + 2));
    chk("tmo_fail", 32'(result_fail), 32'h1);
    chk("tmo_valid", 32'(result_valid), 32'h0);
    chk("tmo_poly_kept", 32'(result_polynomial), 32'h0ABCD);
    chk("tmo_enable", 32'(finder_enable), 32'h0);
    tick(); @(negedge clk_72MHz);
    chk("tmo_back_idle", 32'(busy), 32'h0);
    chk("tmo_promote", 32'(decoded_data), 32'h07777);
    tick();

    // Drops while busy, then saturation.
    send(17'h08888, 24'h200200);
    word_valid = 1'b1; repeat (3) tick(); word_valid = 1'b0;
    @(negedge clk_72MHz); chk("drop3", 32'(drop_count), 32'd3);
    tick();
    word_valid = 1'b1; repeat (300) tick(); word_valid = 1'b0;
    @(negedge clk_72MHz); chk("drop_sat", 32'(drop_count), 32'd255);
    wait_pulse(TMO + 50, n);
    tick(); tick();

    // Reset in the middle of a finder run.
    fmode = 0; fdelay = 50;
    send(17'h09999, 24'h200300);
    repeat (10) tick();
    reset = 1'b1; #1;
    chk("midrst_enable", 32'(finder_enable), 32'h0);
    chk("midrst_valid", 32'(result_valid), 32'h0);
    chk("midrst_fail", 32'(result_fail), 32'h0);
    chk("midrst_newer", 32'(decoded_data1), 32'h0);
    chk("midrst_poly", 32'(result_polynomial), 32'h0);
    chk("midrst_drops", 32'(drop_count), 32'h0);
    tick(); reset = 1'b0;
    send(17'h0AAAA, 24'h000010); tick();
    send(17'h0BBBB, 24'h000020);
    @(negedge clk_72MHz); chk("postrst_enable", 32'(finder_enable), 32'h1);
    wait_pulse(100, n);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (!finder_enable) begin
        fmode  = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 2));
        fdelay = int'($urandom_range(1, 30));
        fpoly  = ($urandom_range(0, 7) == 0) ? 17'h0 : 17'($urandom);
        fiter  = 17'($urandom);
      end
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      word_valid = ($urandom_range(0, 3) == 0);
      if (word_valid) begin
        case ($urandom_range(0, 15))
          0, 1:    cur_ts = cur_ts;
          2, 3:    cur_ts = cur_ts + 24'h200000 + 24'($urandom_range(0, 255));
          4:       cur_ts = cur_ts + MAX_GAP;
          default: cur_ts = cur_ts + 24'($urandom_range(1, 4096));
        endcase
        word_data = ($urandom_range(0, 4) == 0) ? last_d : 17'($urandom);
        word_ts = cur_ts;
        last_d = word_data;
      end
      tick();
    end
    word_valid = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lfsr_pair_sequencer.md
LFSR_PAIR_SEQUENCER -- requirements
Module: lfsr_pair_sequencer

Interface
REQ-001 SHALL have parameter MAX_GAP, default 24'h1FFFFF: largest accepted timestamp gap between paired words.
REQ-002 SHALL have parameter FINDER_TIMEOUT, default 20'd200000: max cycles to wait for finder completion.
REQ-003 SHALL have port clk_72MHz  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port word_valid  input  1  one-cycle strobe: new decoded word available.
REQ-006 SHALL have port word_data  input  17  decoded LFSR word, sampled when word_valid=1.
REQ-007 SHALL have port word_ts  input  24  free-running timestamp of that word, sampled with word_data.
REQ-008 SHALL have ports decoded_data, decoded_data1  output  17 each  older and newer word of the pair, driven to the finder.
REQ-009 SHALL have ports ts_last_data, ts_last_data1  output  24 each  timestamps of older and newer word.
REQ-010 SHALL have port finder_enable  output  1  level request to the finder.
REQ-011 SHALL have ports finder_ready  input  1, finder_polynomial  input  17, finder_iteration  input  17  finder status and result.
REQ-012 SHALL have ports result_polynomial, result_iteration  output  17 each; result_ts  output  24; result_valid  output  1; result_fail  output  1.
REQ-013 SHALL have ports busy  output  1 and drop_count  output  8.

Function
REQ-014 SHALL implement states EMPTY, HAVE_FIRST, START, WAIT_DONE, RELEASE.
REQ-015 EMPTY: on word_valid SHALL load word into decoded_data/ts_last_data and go to HAVE_FIRST.
REQ-016 HAVE_FIRST: on word_valid SHALL compute gap = (word_ts - ts_last_data) mod 2^24 (24-bit wrap subtraction).
REQ-017 If gap==0, gap>MAX_GAP, or word_data==decoded_data, SHALL replace first word with the new one and stay in HAVE_FIRST; no finder request.
REQ-018 Otherwise SHALL load new word into decoded_data1/ts_last_data1, assert finder_enable next cycle, and go to START.
REQ-019 START: finder_enable=1; SHALL wait for finder_ready==0, then go to WAIT_DONE, clearing the timeout counter.
REQ-020 WAIT_DONE: finder_enable=1; on finder_ready==1 SHALL latch finder_polynomial/finder_iteration into result_*, result_ts=ts_last_data1, and go to RELEASE.
REQ-021 In WAIT_DONE, latched finder_polynomial==0 SHALL pulse result_fail instead of result_valid.
REQ-022 If the WAIT_DONE counter reaches FINDER_TIMEOUT, SHALL pulse result_fail, leave result_* unchanged, go to RELEASE.
REQ-023 RELEASE: finder_enable=0 for exactly one cycle, then newer word SHALL become older (decoded_data<=decoded_data1, ts_last_data<=ts_last_data1) and state SHALL be HAVE_FIRST.
REQ-024 result_valid and result_fail SHALL be single-cycle pulses, asserted the cycle the state enters RELEASE, never simultaneously.
REQ-025 busy SHALL be 1 in START, WAIT_DONE, RELEASE.
REQ-026 word_valid while busy SHALL drop the word and increment drop_count, saturating at 255.
REQ-027 word_valid in the same cycle as the RELEASE->HAVE_FIRST transition SHALL be dropped (counted); no pair formed.
REQ-028 START SHALL not exit on finder_ready==1; a ready that never falls is covered by the same FINDER_TIMEOUT counter running in START.
REQ-029 decoded_data1/ts_last_data1 SHALL be stable whenever finder_enable=1.

Reset
REQ-030 reset=1 SHALL asynchronously force state EMPTY, finder_enable=0, result_valid=0, result_fail=0, busy=0, drop_count=0, and all data/timestamp/result outputs to 0.
REQ-031 After reset release SHALL accept the first word_valid on the following clock edge.
REQ-032 reset asserted mid-WAIT_DONE SHALL deassert finder_enable immediately, emit no result pulse.

Verification
REQ-033 Words 0x1A2B3 @ts 0x000100, 0x0F00F @ts 0x000900; finder model drops ready 1 cycle after enable, raises after 20 cycles with 0x1D258/0x00080 -> result_valid one cycle, result_polynomial=0x1D258, result_iteration=0x00080, result_ts=0x000900; decoded_data then 0x0F00F.
REQ-034 ts 0xFFFF00 then 0x000100 -> gap 0x200, pair formed (wrap), finder_enable asserted.
REQ-035 Second word gap 0x200000 (>MAX_GAP) -> no finder_enable; decoded_data replaced by second word.
REQ-036 Finder never re-raises ready -> result_fail after 200000 cycles in WAIT_DONE, finder_enable low one cycle, back to HAVE_FIRST.
REQ-037 Three word_valid while busy, then 300 more -> drop_count 3, then saturates 255.
REQ-038 reset pulse during WAIT_DONE -> finder_enable 0 same cycle, all outputs 0, no result pulse; next two valid words form a new pair.
